// File: rtl/pc_hazard_ctrl.sv
// Hazard controller and PC-redirect scheduler for the 5-stage MIPS pipeline.
// Combinational controls come from the registered state and the live hazard inputs. Counters and the watchdog are registered.
module pc_hazard_ctrl #(
  parameter int BOOT_CYC = 2,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       id_pcsrc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic [1:0]       pc_sel,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze,
  output logic             hazard_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STALL  = 2'b10,
    ST_FREEZE = 2'b11
  } state_e;

  localparam int BW = (BOOT_CYC > 0) ? $clog2(BOOT_CYC + 1) : 1;
  localparam int RW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [CNT_W-1:0] cnt_freeze_q, cnt_freeze_d;
  logic [RW-1:0]    run_q, run_d;
  logic             timeout_q, timeout_d;

  logic in_boot, load_use, jr_hazard;
  logic r_freeze, r_flush, r_stall;

  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  // jr reads rs in ID; only MEM ALU results and WB can be forwarded there
  assign jr_hazard = (id_pcsrc == 2'b11) && (id_rs != 5'd0) &&
                     ((ex_regwrite && (ex_rd == id_rs)) || (mem_memread && (mem_rd == id_rs)));

  // Reset is folded in so the outputs react immediately to an asynchronous reset
  assign in_boot = reset || (state_q == ST_BOOT);

  always_comb begin
    pc_sel      = 2'b00;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    freeze      = 1'b0;
    r_freeze    = 1'b0;
    r_flush     = 1'b0;
    r_stall     = 1'b0;
    if (in_boot) begin
      pc_hold     = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_busy) begin
      freeze   = 1'b1;
      pc_hold  = 1'b1;
      r_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = 2'b01;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      r_flush     = 1'b1;
    end else if (load_use || jr_hazard) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
      r_stall     = 1'b1;
    end else if (id_pcsrc[1]) begin
      pc_sel      = id_pcsrc;
      if_id_flush = 1'b1;
      r_flush     = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    if (state_q == ST_BOOT) begin
      if (boot_cnt_q <= BW'(1)) state_d = ST_RUN;
      if (boot_cnt_q != '0) boot_cnt_d = boot_cnt_q - 1'b1;
    end else if (r_freeze) begin
      state_d = ST_FREEZE;
    end else if (r_stall) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    cnt_stall_d  = cnt_stall_q;
    cnt_flush_d  = cnt_flush_q;
    cnt_freeze_d = cnt_freeze_q;
    run_d        = '0;
    timeout_d    = timeout_q;
    if (cnt_clr) begin
      cnt_stall_d  = '0;
      cnt_flush_d  = '0;
      cnt_freeze_d = '0;
      timeout_d    = 1'b0;
    end else begin
      if (r_stall && (cnt_stall_q != '1))   cnt_stall_d  = cnt_stall_q + 1'b1;
      if (r_flush && (cnt_flush_q != '1))   cnt_flush_d  = cnt_flush_q + 1'b1;
      if (r_freeze && (cnt_freeze_q != '1)) cnt_freeze_d = cnt_freeze_q + 1'b1;
      if (r_freeze || r_stall) begin
        run_d = (run_q >= RW'(TIMEOUT)) ? run_q : run_q + 1'b1;
        if (run_q >= RW'(TIMEOUT - 1)) timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= (BOOT_CYC == 0) ? ST_RUN : ST_BOOT;
      boot_cnt_q   <= BW'(BOOT_CYC);
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      cnt_freeze_q <= '0;
      run_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
      cnt_freeze_q <= cnt_freeze_d;
      run_q        <= run_d;
      timeout_q    <= timeout_d;
    end
  end

  assign state          = in_boot ? ST_BOOT : state_q;
  assign cnt_stall      = cnt_stall_q;
  assign cnt_flush      = cnt_flush_q;
  assign cnt_freeze     = cnt_freeze_q;
  assign hazard_timeout = timeout_q;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed bench for pc_hazard_ctrl: a rule-level model checked every cycle, plus literal spot checks.
// A second instance with tiny counters and no boot covers saturation and BOOT_CYC = 0.
module tb_pc_hazard_ctrl;

  localparam int BOOT_CYC = 2;
  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 64;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk, reset;
  logic [1:0] id_pcsrc;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, ex_memread, ex_regwrite, mem_memread;
  logic ex_branch_taken, dmem_busy, cnt_clr;

  logic [1:0] pc_sel, state;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_flush, freeze, hazard_timeout;
  logic [CNT_W-1:0] cnt_stall, cnt_flush, cnt_freeze;

  logic [1:0] s2_pc_sel, s2_state;
  logic s2_pc_hold, s2_if_id_hold, s2_if_id_flush, s2_id_ex_flush, s2_freeze, s2_timeout;
  logic [1:0] s2_cnt_stall, s2_cnt_flush, s2_cnt_freeze;

  int checks = 0;
  int errors = 0;

  pc_hazard_ctrl #(.BOOT_CYC(BOOT_CYC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_sel(pc_sel), .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .freeze(freeze), .state(state), .cnt_stall(cnt_stall),
    .cnt_flush(cnt_flush), .cnt_freeze(cnt_freeze), .hazard_timeout(hazard_timeout)
  );

  pc_hazard_ctrl #(.BOOT_CYC(0), .CNT_W(2), .TIMEOUT(4)) dut2 (
    .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_sel(s2_pc_sel), .pc_hold(s2_pc_hold), .if_id_hold(s2_if_id_hold),
    .if_id_flush(s2_if_id_flush), .id_ex_flush(s2_id_ex_flush), .freeze(s2_freeze),
    .state(s2_state), .cnt_stall(s2_cnt_stall), .cnt_flush(s2_cnt_flush),
    .cnt_freeze(s2_cnt_freeze), .hazard_timeout(s2_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-level model: which rule fires this cycle, per-event integer counters
  int m_boot = BOOT_CYC;
  int m_st   = 1;
  int m_cs = 0, m_cf = 0, m_cz = 0, m_run = 0;
  bit m_to = 1'b0;

  function automatic int rule_now();
    if (dmem_busy) return 1;
    if (ex_branch_taken) return 2;
    if (ex_memread && ex_rd != 0 &&
        ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd))) return 3;
    if (id_pcsrc == 2'b11 && id_rs != 0 &&
        ((ex_regwrite && ex_rd == id_rs) || (mem_memread && mem_rd == id_rs))) return 4;
    if (id_pcsrc >= 2'b10) return 5;
    return 6;
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_boot = BOOT_CYC; m_st = 1;
      m_cs = 0; m_cf = 0; m_cz = 0; m_run = 0; m_to = 1'b0;
    end else if (m_boot > 0) begin
      m_boot = m_boot - 1;
      m_run  = 0;
    end else begin
      int r;
      r = rule_now();
      if (cnt_clr) begin
        m_cs = 0; m_cf = 0; m_cz = 0; m_run = 0; m_to = 1'b0;
      end else begin
        if (r == 1) m_cz = sat(m_cz);
        if (r == 3 || r == 4) m_cs = sat(m_cs);
        if (r == 2 || r == 5) m_cf = sat(m_cf);
        if (r == 1 || r == 3 || r == 4) begin
          m_run = m_run + 1;
          if (m_run >= TIMEOUT) m_to = 1'b1;
        end else begin
          m_run = 0;
        end
      end
      m_st = (r == 1) ? 3 : ((r == 3 || r == 4) ? 2 : 1);
    end
  end

  always @(negedge clk) begin
    logic [63:0] act, exp;
    logic [1:0] e_sel, e_st;
    logic e_hold, e_ifh, e_iff, e_idf, e_frz;
    int r;
    e_sel = 2'b00; e_hold = 0; e_ifh = 0; e_iff = 0; e_idf = 0; e_frz = 0;
    if (reset || m_boot > 0) begin
      e_hold = 1; e_iff = 1; e_idf = 1; e_st = 2'b00;
    end else begin
      e_st = 2'(m_st);
      r = rule_now();
      case (r)
        1: begin e_hold = 1; e_frz = 1; end
        2: begin e_sel = 2'b01; e_iff = 1; e_idf = 1; end
        3, 4: begin e_hold = 1; e_ifh = 1; e_idf = 1; end
        5: begin e_sel = id_pcsrc; e_iff = 1; end
        default: ;
      endcase
    end
    act = {6'd0, pc_sel, pc_hold, if_id_hold, if_id_flush, id_ex_flush, freeze, state,
           hazard_timeout, cnt_stall, cnt_flush, cnt_freeze};
    exp = {6'd0, e_sel, e_hold, e_ifh, e_iff, e_idf, e_frz, e_st, m_to,
           CNT_W'(m_cs), CNT_W'(m_cf), CNT_W'(m_cz)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle();
    id_pcsrc = 2'b00; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_memread = 0; mem_rd = 0;
    ex_branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cnt_clr = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_pc_hold", pc_hold, 1);
    chk("rst_id_ex_flush", id_ex_flush, 1);
    chk("rst_freeze", freeze, 0);
    reset = 1'b0; #1;
    chk("boot1_state", state, 0);
    chk("boot1_if_id_flush", if_id_flush, 1);
    chk("noboot_state", s2_state, 1);
    step();
    chk("boot2_pc_hold", pc_hold, 1);
    step();
    chk("run_state", state, 1);
    chk("run_pc_hold", pc_hold, 0);

    // lw $8 in EX, add reads $8 in ID
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_if_id_hold", if_id_hold, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    step(); ex_memread = 0; #1;
    chk("lu_state", state, 2);
    chk("lu_released", pc_hold, 0);
    chk("lu_cnt_stall", cnt_stall, 1);
    step();
    chk("lu_back_run", state, 1);
    idle(); cnt_clr = 1; step(); cnt_clr = 0; #1;
    chk("clr_cnt_stall", cnt_stall, 0);

    // jr $31: EX writes $31, then MEM load to $31, then redirect
    id_pcsrc = 2'b11; id_rs = 31; id_uses_rs = 1; ex_regwrite = 1; ex_rd = 31; #1;
    chk("jr1_pc_hold", pc_hold, 1);
    step(); ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 31; #1;
    chk("jr2_pc_hold", pc_hold, 1);
    step(); mem_memread = 0; #1;
    chk("jr_pc_sel", pc_sel, 3);
    chk("jr_if_id_flush", if_id_flush, 1);
    step(); idle(); #1;
    chk("jr_cnt_stall", cnt_stall, 2);
    chk("jr_cnt_flush", cnt_flush, 1);

    // taken branch beats a jump and a load-use
    ex_branch_taken = 1; id_pcsrc = 2'b10; ex_memread = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; #1;
    chk("br_pc_sel", pc_sel, 1);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    chk("br_no_hold", pc_hold, 0);
    step(); idle(); #1;
    chk("br_cnt_stall", cnt_stall, 2);
    chk("br_cnt_flush", cnt_flush, 2);

    // 70 cycles of dmem_busy over a taken branch
    dmem_busy = 1; ex_branch_taken = 1;
    for (int k = 1; k <= 70; k++) begin
      #1;
      chk("frz_freeze", freeze, 1);
      if (k == 64) chk("frz_timeout_pre", hazard_timeout, 0);
      if (k == 65) chk("frz_timeout_set", hazard_timeout, 1);
      step();
    end
    dmem_busy = 0; #1;
    chk("frz_redirect", pc_sel, 1);
    chk("frz_state", state, 3);
    chk("frz_cnt_freeze", cnt_freeze, 70);
    chk("frz_sat_small", s2_cnt_freeze, 3);
    step(); idle(); #1;
    chk("frz_timeout_sticky", hazard_timeout, 1);
    cnt_clr = 1; step(); cnt_clr = 0; #1;
    chk("clr_cnt_freeze", cnt_freeze, 0);
    chk("clr_cnt_flush", cnt_flush, 0);
    chk("clr_timeout", hazard_timeout, 0);

    // four consecutive load-use stalls via rt
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
    repeat (4) step();
    idle(); #1;
    chk("sat_cnt_stall", cnt_stall, 4);
    chk("sat_small_cnt_stall", s2_cnt_stall, 3);
    chk("small_timeout", s2_timeout, 1);
    chk("no_timeout", hazard_timeout, 0);

    // asynchronous reset in the middle of a stall
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
    step(); #2;
    reset = 1'b1; #1;
    chk("areset_state", state, 0);
    chk("areset_if_id_hold", if_id_hold, 0);
    chk("areset_pc_hold", pc_hold, 1);
    chk("areset_cnt_stall", cnt_stall, 0);
    idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
